// File: rtl/x_23k640_req_q_if.sv
// Request/response and controller-side handshake bundle for the 23K640 request queue.
// Handshakes: a request moves on i_req_valid & o_req_ready; the head moves on o_valid & i_accept.
interface x_23k640_req_q_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_rd_n_wr;
  logic [15:0] i_req_addr;
  logic [7:0]  i_req_wdata;
  logic        o_rsp_valid;
  logic [7:0]  o_rsp_rdata;
  logic        o_advance;
  logic        o_valid;
  logic        i_accept;
  logic        o_rd_n_wr;
  logic [15:0] o_addr;
  logic [7:0]  o_wdata;
  logic        i_ready;
  logic [7:0]  i_rdata;

  modport slave (
    input  i_req_valid, i_req_rd_n_wr, i_req_addr, i_req_wdata,
    input  i_accept, i_ready, i_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_advance,
    output o_valid, o_rd_n_wr, o_addr, o_wdata
  );

  modport master (
    output i_req_valid, i_req_rd_n_wr, i_req_addr, i_req_wdata,
    output i_accept, i_ready, i_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_advance,
    input  o_valid, o_rd_n_wr, o_addr, o_wdata
  );
endinterface

// File: rtl/x_23k640_req_q.sv
// Request FIFO, read-outstanding tracker, completion register and advance pacer
// in front of the 23K640 SPI SRAM controller.
module x_23k640_req_q #(
  parameter int DEPTH   = 4,
  parameter int ADV_DIV = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  x_23k640_req_q_if.slave        bus,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_idle,
  output logic                   o_err,
  output logic [1:0]             o_dbg_rd_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (ADV_DIV > 1) ? $clog2(ADV_DIV) : 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [DW-1:0] ADV_LAST = DW'(ADV_DIV - 1);

  logic [24:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    rd_out_q, rd_out_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;
  logic [DW-1:0] adv_cnt_q, adv_cnt_d;
  logic          adv_q, adv_d;
  logic          err_q, err_d;
  logic          full, empty, push, pop, rd_inc;
  logic [24:0]   head;

  assign full  = (count_q == FULL);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Head is read straight from storage so it cannot change until the pop.
  assign bus.o_req_ready = ~full;
  assign bus.o_valid     = ~empty;
  assign bus.o_rd_n_wr   = head[24];
  assign bus.o_addr      = head[23:8];
  assign bus.o_wdata     = head[7:0];
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_rdata = rsp_rdata_q;
  assign bus.o_advance   = adv_q;
  assign o_level         = count_q;
  assign o_idle          = empty & (rd_out_q == 2'd0);
  assign o_err           = err_q;
  assign o_dbg_rd_out    = rd_out_q;

  always_comb begin
    push        = bus.i_req_valid & ~full;
    pop         = bus.i_accept & ~empty;
    rd_inc      = pop & head[24];
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q;
    rd_out_d    = rd_out_q;
    err_d       = err_q;
    rsp_valid_d = bus.i_ready;
    rsp_rdata_d = bus.i_ready ? bus.i_rdata : rsp_rdata_q;
    adv_cnt_d   = (adv_cnt_q == ADV_LAST) ? '0 : adv_cnt_q + 1'b1;
    adv_d       = (adv_cnt_q == ADV_LAST);

    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

    // A simultaneous issue and completion cancel out.
    if (rd_inc && !bus.i_ready) begin
      if (rd_out_q == 2'd3) err_d = 1'b1;
      else                  rd_out_d = rd_out_q + 1'b1;
    end else if (!rd_inc && bus.i_ready && rd_out_q != 2'd0) begin
      rd_out_d = rd_out_q - 1'b1;
    end

    if (bus.i_accept && empty)                  err_d = 1'b1;
    if (bus.i_ready && rd_out_q == 2'd0)        err_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.i_req_rd_n_wr, bus.i_req_addr, bus.i_req_wdata};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_out_q    <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      adv_cnt_q   <= '0;
      adv_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_out_q    <= rd_out_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      adv_cnt_q   <= adv_cnt_d;
      adv_q       <= adv_d;
      err_q       <= err_d;
    end
  end
endmodule
